// File: rtl/vmul_seq.sv
// rtl/vmul_seq.sv - vector-multiply sequencer feeding mult_256bit and merging its result
//
// Accepts one (sew, vl) command, streams operand beats through a registered
// operand stage (S1) into the external combinational multiplier, registers the
// tail-merged product in S2 and hands it to writeback.
//
// Ports:
//   clk_i, rst_i                   clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o        command handshake (ready only in IDLE)
//   cmd_sew_i, cmd_vl_i            element width code and element count
//   op_valid_i/op_ready_o          operand-beat handshake
//   op_a_i, op_b_i, op_vd_i        multiplicand, multiplier, old destination
//   mul_a_o, mul_b_o, mul_sew_o    to the multiplier (from S1 registers)
//   mul_out_i                      multiplier product (combinational)
//   res_valid_o/res_ready_i        result handshake
//   res_data_o, res_idx_o          merged beat and its index in the group
//   res_last_o                     final beat of the command
//   done_o, err_o                  completion / rejection pulses
module vmul_seq #(
    parameter int MAX_BEATS = 8,
    parameter int VL_W      = 9
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic [2:0]      cmd_sew_i,
    input  logic [VL_W-1:0] cmd_vl_i,
    input  logic            op_valid_i,
    output logic            op_ready_o,
    input  logic [255:0]    op_a_i,
    input  logic [255:0]    op_b_i,
    input  logic [255:0]    op_vd_i,
    output logic [255:0]    mul_a_o,
    output logic [255:0]    mul_b_o,
    output logic [2:0]      mul_sew_o,
    input  logic [255:0]    mul_out_i,
    output logic            res_valid_o,
    input  logic            res_ready_i,
    output logic [255:0]    res_data_o,
    output logic [2:0]      res_idx_o,
    output logic            res_last_o,
    output logic            done_o,
    output logic            err_o
);

    localparam int CNT_W  = 4;
    localparam int IDX_W  = 3;
    localparam int CALC_W = VL_W + 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [2:0]        sew_q;
    logic [VL_W-1:0]   vl_q;
    logic [CNT_W-1:0]  beats_q, issued_q, retired_q;
    logic              s1_valid_q;
    logic [255:0]      s1_a_q, s1_b_q, s1_vd_q;
    logic [IDX_W-1:0]  s1_idx_q;
    logic              s2_valid_q;
    logic [255:0]      s2_data_q;
    logic [IDX_W-1:0]  s2_idx_q;

    // Command decode: beats = ceil(vl / EPB) with EPB = 1 << (5 - sew).
    logic [2:0]        cmd_shift;
    logic [CALC_W-1:0] cmd_vl_ext, cmd_limit, cmd_beats_full;
    logic [CNT_W-1:0]  cmd_beats;
    logic              cmd_bad, cmd_empty;

    always_comb begin
        cmd_shift      = 3'd5 - {1'b0, cmd_sew_i[1:0]};
        cmd_vl_ext     = CALC_W'(cmd_vl_i);
        cmd_limit      = CALC_W'(MAX_BEATS) << cmd_shift;
        cmd_beats_full = (cmd_vl_ext + (CALC_W'(1) << cmd_shift) - CALC_W'(1)) >> cmd_shift;
        cmd_beats      = cmd_beats_full[CNT_W-1:0];
        // sew codes 4..7 are illegal; the limit is only meaningful for 0..3
        cmd_bad        = cmd_sew_i[2] | (cmd_vl_ext > cmd_limit);
        cmd_empty      = (cmd_vl_i == '0);
    end

    logic adv, cmd_fire, cmd_accept, op_fire, res_fire, last_issue, last_retire;

    // Global stall: both stages advance only when S2 is empty or draining.
    assign adv         = ~s2_valid_q | res_ready_i;
    assign cmd_fire    = cmd_valid_i & cmd_ready_q;
    assign cmd_accept  = cmd_fire & ~cmd_bad & ~cmd_empty;
    assign op_ready_o  = (state_q == ST_RUN) & (issued_q < beats_q) & adv;
    assign op_fire     = op_valid_i & op_ready_o;
    assign res_fire    = s2_valid_q & res_ready_i;
    assign last_issue  = op_fire & (issued_q == beats_q - CNT_W'(1));
    assign last_retire = res_fire & (retired_q == beats_q - CNT_W'(1));

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    if (cmd_bad) begin
                        err_d = 1'b1;
                    end else if (cmd_empty) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (last_issue) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (last_retire) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Registered ready: low during reset, high the cycle done_o pulses.
        cmd_ready_d = (state_d == ST_IDLE);
    end

    // Tail merge: byte b belongs to element (b >> sew) of beat s1_idx.
    logic [2:0]        s1_shift;
    logic [CALC_W-1:0] elem_base, elem_idx;
    logic [255:0]      merged;

    always_comb begin
        merged    = '0;
        elem_idx  = '0;
        s1_shift  = 3'd5 - {1'b0, sew_q[1:0]};
        elem_base = CALC_W'(s1_idx_q) << s1_shift;
        for (int b = 0; b < 32; b++) begin
            elem_idx = elem_base + (CALC_W'(b) >> sew_q[1:0]);
            merged[8*b +: 8] = (elem_idx < CALC_W'(vl_q)) ? mul_out_i[8*b +: 8]
                                                          : s1_vd_q[8*b +: 8];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            sew_q       <= '0;
            vl_q        <= '0;
            beats_q     <= '0;
            issued_q    <= '0;
            retired_q   <= '0;
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_vd_q     <= '0;
            s1_idx_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_data_q   <= '0;
            s2_idx_q    <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            done_q      <= done_d;
            err_q       <= err_d;

            if (cmd_accept) begin
                sew_q     <= cmd_sew_i;
                vl_q      <= cmd_vl_i;
                beats_q   <= cmd_beats;
                issued_q  <= '0;
                retired_q <= '0;
            end else begin
                if (op_fire) begin
                    issued_q <= issued_q + CNT_W'(1);
                end
                if (res_fire) begin
                    retired_q <= retired_q + CNT_W'(1);
                end
            end

            if (adv) begin
                s1_valid_q <= op_fire;
                if (op_fire) begin
                    s1_a_q   <= op_a_i;
                    s1_b_q   <= op_b_i;
                    s1_vd_q  <= op_vd_i;
                    s1_idx_q <= issued_q[IDX_W-1:0];
                end
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_data_q <= merged;
                    s2_idx_q  <= s1_idx_q;
                end
            end
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign mul_a_o     = s1_a_q;
    assign mul_b_o     = s1_b_q;
    assign mul_sew_o   = sew_q;
    assign res_valid_o = s2_valid_q;
    assign res_data_o  = s2_data_q;
    assign res_idx_o   = s2_idx_q;
    assign res_last_o  = s2_valid_q & ({1'b0, s2_idx_q} == beats_q - CNT_W'(1));
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_vmul_seq.sv
// tb/tb_vmul_seq.sv - self-checking bench for vmul_seq with a behavioural multiplier
module tb_vmul_seq;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         cmd_valid_i;
    logic         cmd_ready_o;
    logic [2:0]   cmd_sew_i;
    logic [8:0]   cmd_vl_i;
    logic         op_valid_i;
    logic         op_ready_o;
    logic [255:0] op_a_i, op_b_i, op_vd_i;
    logic [255:0] mul_a_o, mul_b_o, mul_out_i;
    logic [2:0]   mul_sew_o;
    logic         res_valid_o;
    logic         res_ready_i;
    logic [255:0] res_data_o;
    logic [2:0]   res_idx_o;
    logic         res_last_o;
    logic         done_o;
    logic         err_o;

    int errors = 0;
    int checks = 0;

    logic [255:0] ga [8];
    logic [255:0] gb [8];
    logic [255:0] gvd [8];

    always #5 clk = ~clk;

    vmul_seq #(.MAX_BEATS(8), .VL_W(9)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_sew_i   (cmd_sew_i),
        .cmd_vl_i    (cmd_vl_i),
        .op_valid_i  (op_valid_i),
        .op_ready_o  (op_ready_o),
        .op_a_i      (op_a_i),
        .op_b_i      (op_b_i),
        .op_vd_i     (op_vd_i),
        .mul_a_o     (mul_a_o),
        .mul_b_o     (mul_b_o),
        .mul_sew_o   (mul_sew_o),
        .mul_out_i   (mul_out_i),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .res_data_o  (res_data_o),
        .res_idx_o   (res_idx_o),
        .res_last_o  (res_last_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    // Element-wise unsigned product truncated to the element width.
    function automatic logic [255:0] elem_mul(input logic [255:0] a, input logic [255:0] b,
                                              input logic [1:0] sew);
        int w;
        logic [63:0] m, ea, eb, p;
        logic [255:0] r;
        w = 8 << sew;
        m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        r = '0;
        for (int j = 0; j < 256 / w; j++) begin
            ea = 64'(a >> (j * w)) & m;
            eb = 64'(b >> (j * w)) & m;
            p  = (ea * eb) & m;
            r  = r | (256'(p) << (j * w));
        end
        return r;
    endfunction

    assign mul_out_i = elem_mul(mul_a_o, mul_b_o, mul_sew_o[1:0]);

    // Expected beat k: element g = k*EPB + j is the product if g < vl, else old vd.
    function automatic logic [255:0] exp_beat(input int k, input int sew, input int vl);
        int w, epb;
        logic [63:0] m, e;
        logic [255:0] prod, r;
        w    = 8 << sew;
        epb  = 32 >> sew;
        m    = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        prod = elem_mul(ga[k], gb[k], 2'(sew));
        r    = '0;
        for (int j = 0; j < epb; j++) begin
            if (k * epb + j < vl) e = 64'(prod >> (j * w)) & m;
            else                  e = 64'(gvd[k] >> (j * w)) & m;
            r = r | (256'(e) << (j * w));
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 8; i++) begin
            ga[i] = rand256(); gb[i] = rand256(); gvd[i] = rand256();
        end
    endtask

    task automatic fill_const(input logic [255:0] a, input logic [255:0] b, input logic [255:0] vd);
        for (int i = 0; i < 8; i++) begin
            ga[i] = a; gb[i] = b; gvd[i] = vd;
        end
    endtask

    task automatic send_cmd(input int sew, input int vl);
        int c;
        op_valid_i  = 1'b0;
        cmd_valid_i = 1'b1;
        cmd_sew_i   = 3'(sew);
        cmd_vl_i    = 9'(vl);
        c = 0;
        while (cmd_ready_o !== 1'b1 && c < 50) begin
            tick();
            c++;
        end
        check("cmd_ready_wait", 256'(cmd_ready_o), 256'(1));
        tick();
        // Scramble command fields: the block must have sampled them already.
        cmd_valid_i = 1'b0;
        cmd_sew_i   = 3'($urandom);
        cmd_vl_i    = 9'($urandom);
    endtask

    // mode 0: always ready; 1: ready pattern 1,0,0; 2: random ready and operand gaps.
    task automatic run_cmd(input int sew, input int vl, input int mode, input int abort_at);
        int epb, nb, oi, ri, cyc, first_op, first_res;
        bit op_f, prev_stall, aborted;
        logic [255:0] prev_data;
        logic [2:0] prev_idx;
        logic [255:0] expq [8];
        epb = 32 >> sew;
        nb  = (vl + epb - 1) / epb;
        for (int k = 0; k < nb; k++) expq[k] = exp_beat(k, sew, vl);
        send_cmd(sew, vl);
        oi = 0; ri = 0; cyc = 0; first_op = -1; first_res = -1;
        prev_stall = 1'b0; aborted = 1'b0; prev_data = '0; prev_idx = '0;
        while (ri < nb && cyc < 400 && !aborted) begin
            op_valid_i = (oi < nb) && (mode != 2 || ($urandom % 4) != 0);
            if (oi < nb) begin
                op_a_i = ga[oi]; op_b_i = gb[oi]; op_vd_i = gvd[oi];
            end else begin
                op_a_i = rand256(); op_b_i = rand256(); op_vd_i = rand256();
            end
            case (mode)
                0:       res_ready_i = 1'b1;
                1:       res_ready_i = (cyc % 3 == 0);
                default: res_ready_i = (($urandom % 4) != 0);
            endcase
            #4;
            op_f = op_valid_i && op_ready_o;
            if (prev_stall) begin
                check("stall_data", res_data_o, prev_data);
                check("stall_idx", 256'(res_idx_o), 256'(prev_idx));
            end
            if (res_valid_o && !res_ready_i) begin
                check("op_ready_stall", 256'(op_ready_o), 256'(0));
                prev_stall = 1'b1; prev_data = res_data_o; prev_idx = res_idx_o;
            end else begin
                prev_stall = 1'b0;
            end
            if (op_f && first_op < 0) first_op = cyc;
            if (res_valid_o && first_res < 0) first_res = cyc;
            if (res_valid_o && res_ready_i) begin
                check("res_idx", 256'(res_idx_o), 256'(ri));
                check("res_data", res_data_o, expq[ri]);
                check("res_last", 256'(res_last_o), 256'(ri == nb - 1));
                ri++;
            end
            check("done_early", 256'(done_o), 256'(0));
            @(posedge clk);
            #1;
            cyc++;
            if (op_f) begin
                if (oi == abort_at) aborted = 1'b1;
                oi++;
            end
        end
        op_valid_i  = 1'b0;
        res_ready_i = 1'b0;
        if (!aborted) begin
            check("beats_seen", 256'(ri), 256'(nb));
            check("done_pulse", 256'(done_o), 256'(1));
            check("cmd_ready_at_done", 256'(cmd_ready_o), 256'(1));
            check("res_valid_after", 256'(res_valid_o), 256'(0));
            check("mul_sew_latched", 256'(mul_sew_o), 256'(sew));
            if (mode == 0) check("latency", 256'(first_res - first_op), 256'(2));
            tick();
            check("done_one_cycle", 256'(done_o), 256'(0));
        end
    endtask

    task automatic reject_cmd(input int sew, input int vl, input bit expect_err);
        send_cmd(sew, vl);
        check("err_pulse", 256'(err_o), 256'(expect_err));
        check("done_on_reject", 256'(done_o), 256'(!expect_err));
        check("ready_after_reject", 256'(cmd_ready_o), 256'(1));
        check("no_res_on_reject", 256'(res_valid_o), 256'(0));
        tick();
        check("pulses_cleared", 256'({err_o, done_o, res_valid_o, op_ready_o}), 256'(0));
    endtask

    initial begin
        int sew, epb, vl;
        rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_sew_i = '0; cmd_vl_i = '0;
        op_valid_i = 1'b0; op_a_i = '0; op_b_i = '0; op_vd_i = '0; res_ready_i = 1'b0;
        fill_const('0, '0, '0);

        // Reset state
        tick(); tick();
        check("reset_ctrl", 256'({cmd_ready_o, op_ready_o, res_valid_o, res_last_o,
                                  done_o, err_o, res_idx_o, mul_sew_o}), 256'(0));
        check("reset_data", res_data_o | mul_a_o | mul_b_o, '0);
        rst_i = 1'b0;
        tick();
        check("ready_after_reset", 256'(cmd_ready_o), 256'(1));

        // Single-beat byte multiply
        fill_const({32{8'h03}}, {32{8'h05}}, rand256());
        run_cmd(0, 32, 0, -1);

        // 32-bit wrap with tail-undisturbed words 5..7
        fill_const({8{32'h0001_0000}}, {8{32'h0001_0000}}, {8{32'hDEAD_BEEF}});
        run_cmd(2, 5, 0, -1);

        // 64-bit, full 8 beats, ready pattern 1,0,0
        fill_random();
        run_cmd(3, 32, 1, -1);

        // Rejected and empty commands
        reject_cmd(4, 8, 1'b1);
        reject_cmd(3, 33, 1'b1);
        reject_cmd(0, 0, 1'b0);

        // Randomised commands, including boundary lengths
        for (int t = 0; t < 10; t++) begin
            sew = int'($urandom % 4);
            epb = 32 >> sew;
            case (t % 3)
                0:       vl = 8 * epb;
                1:       vl = epb * int'($urandom_range(1, 7)) + 1;
                default: vl = int'($urandom_range(1, 8 * epb));
            endcase
            fill_random();
            run_cmd(sew, vl, (t % 4 == 0) ? 0 : 2, -1);
        end

        // Reset mid-command after beat 2 is accepted
        fill_random();
        run_cmd(1, 64, 0, 2);
        rst_i = 1'b1;
        tick();
        check("midreset_ctrl", 256'({cmd_ready_o, op_ready_o, res_valid_o, res_last_o,
                                     done_o, err_o, res_idx_o, mul_sew_o}), 256'(0));
        check("midreset_data", res_data_o | mul_a_o | mul_b_o, '0);
        rst_i = 1'b0;
        res_ready_i = 1'b1;
        tick();
        check("midreset_ready", 256'(cmd_ready_o), 256'(1));
        for (int i = 0; i < 4; i++) begin
            check("midreset_quiet", 256'({done_o, res_valid_o, op_ready_o}), 256'(0));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
